// File: rtl/alu_issue_unit_if.sv
// ============================================================================
//  Module      : alu_issue_unit_if
//  Description : Command handshake bundle for alu_issue_unit. The master
//                (command source) presents an instruction with valid; the
//                slave (issue unit) answers with ready.
//  Ports       : cmd_valid/cmd_ready handshake, cmd_op (5b opcode),
//                cmd_rd/cmd_rn/cmd_rm (3b register indices),
//                cmd_imm_sel (num2 from immediate), cmd_imm (8b immediate)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_issue_unit_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [4:0] cmd_op;
    logic [2:0] cmd_rd;
    logic [2:0] cmd_rn;
    logic [2:0] cmd_rm;
    logic       cmd_imm_sel;
    logic [7:0] cmd_imm;

    modport master (
        output cmd_valid, cmd_op, cmd_rd, cmd_rn, cmd_rm, cmd_imm_sel, cmd_imm,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_rd, cmd_rn, cmd_rm, cmd_imm_sel, cmd_imm,
        output cmd_ready
    );
endinterface

`default_nettype wire

// File: rtl/alu_issue_unit.sv
// ============================================================================
//  Module      : alu_issue_unit
//  Description : Single-issue sequencer in front of an external registered
//                ALU. Owns an 8 x 32-bit register file and the architectural
//                flags. Each command walks IDLE -> ISSUE -> WB -> IDLE.
//  Ports       : clk, rst_n (async, active-low)
//                cmd            - command handshake (alu_issue_unit_if.slave)
//                alu_*          - operands/opcode to ALU, result/flags back
//                wb_valid/rd/data - register-write report (1-cycle pulse)
//                done, err      - completion / illegal-op pulses
//                flags_q        - architectural flags
//                dbg_addr/data  - combinational register file peek
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_issue_unit (
    input  wire logic        clk,
    input  wire logic        rst_n,
    alu_issue_unit_if.slave  cmd,
    output logic [4:0]       alu_instruction,
    output logic [31:0]      alu_num1,
    output logic [31:0]      alu_num2,
    input  wire logic [31:0] alu_result,
    input  wire logic [3:0]  alu_flags,
    output logic             wb_valid,
    output logic [2:0]       wb_rd,
    output logic [31:0]      wb_data,
    output logic             done,
    output logic             err,
    output logic [3:0]       flags_q,
    input  wire logic [2:0]  dbg_addr,
    output logic [31:0]      dbg_data
);

    localparam logic [4:0] c_op_mvns = 5'd3;
    localparam logic [4:0] c_op_uxtb = 5'd14;
    localparam logic [4:0] c_op_uxth = 5'd15;
    localparam logic [4:0] c_op_sxtb = 5'd16;
    localparam logic [4:0] c_op_sxth = 5'd17;
    localparam logic [4:0] c_op_cmp  = 5'd18;
    localparam logic [4:0] c_op_movi = 5'd19;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WB    = 2'd2
    } state_t;

    state_t      r_state;
    logic [4:0]  r_op;
    logic [2:0]  r_rd;
    logic [7:0]  r_imm;
    logic [31:0] r_rf [0:7];

    // Ops that actually go to the ALU (result and/or flags consumed).
    function automatic logic is_alu_op(input logic [4:0] op);
        return (op >= 5'd1) && (op <= c_op_cmp);
    endfunction

    // Ops whose ALU result is written back to the register file.
    function automatic logic is_rf_op(input logic [4:0] op);
        return (op >= 5'd1) && (op <= c_op_sxth);
    endfunction

    function automatic logic is_unary(input logic [4:0] op);
        return (op == c_op_mvns) || (op == c_op_uxtb) || (op == c_op_uxth) ||
               (op == c_op_sxtb) || (op == c_op_sxth);
    endfunction

    logic [31:0] w_num2;

    // Gated with rst_n so the unit never advertises ready while held in reset.
    assign cmd.cmd_ready = rst_n && (r_state == S_IDLE);
    assign dbg_data      = r_rf[dbg_addr];

    always_comb begin
        w_num2 = cmd.cmd_imm_sel ? {24'b0, cmd.cmd_imm} : r_rf[cmd.cmd_rm];
        if (is_unary(cmd.cmd_op)) begin
            w_num2 = 32'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= S_IDLE;
            r_op            <= 5'd0;
            r_rd            <= 3'd0;
            r_imm           <= 8'd0;
            alu_instruction <= 5'd0;
            alu_num1        <= 32'd0;
            alu_num2        <= 32'd0;
            wb_valid        <= 1'b0;
            wb_rd           <= 3'd0;
            wb_data         <= 32'd0;
            done            <= 1'b0;
            err             <= 1'b0;
            flags_q         <= 4'd0;
            for (int i = 0; i < 8; i++) begin
                r_rf[i] <= 32'd0;
            end
        end else begin
            // Report signals are single-cycle pulses.
            wb_valid <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (cmd.cmd_valid) begin
                        // Operands are captured here so a later write to the
                        // same register cannot alter an in-flight command.
                        r_op            <= cmd.cmd_op;
                        r_rd            <= cmd.cmd_rd;
                        r_imm           <= cmd.cmd_imm;
                        alu_instruction <= is_alu_op(cmd.cmd_op) ? cmd.cmd_op : 5'd0;
                        alu_num1        <= r_rf[cmd.cmd_rn];
                        alu_num2        <= w_num2;
                        r_state         <= S_ISSUE;
                    end
                end

                // ALU registers its result on the edge leaving ISSUE.
                S_ISSUE: begin
                    r_state <= S_WB;
                end

                S_WB: begin
                    if (is_rf_op(r_op)) begin
                        r_rf[r_rd] <= alu_result;
                        wb_valid   <= 1'b1;
                        wb_rd      <= r_rd;
                        wb_data    <= alu_result;
                    end else if (r_op == c_op_movi) begin
                        r_rf[r_rd] <= {24'b0, r_imm};
                        wb_valid   <= 1'b1;
                        wb_rd      <= r_rd;
                        wb_data    <= {24'b0, r_imm};
                    end
                    if (is_alu_op(r_op)) begin
                        flags_q <= alu_flags;
                    end
                    done            <= 1'b1;
                    err             <= !is_alu_op(r_op) && (r_op != c_op_movi);
                    alu_instruction <= 5'd0;
                    r_state         <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/alu_issue_unit.md
ALU_ISSUE_UNIT -- requirements
Module: alu_issue_unit

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-002 SHALL have: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have: cmd_valid in 1 command present; cmd_ready out 1 unit can accept.
REQ-004 SHALL have: cmd_op in 5, ALU instruction code (1..18 ALU ops, 19 MOVI, others illegal).
REQ-005 SHALL have: cmd_rd, cmd_rn, cmd_rm  in  3 each  destination/source register indices.
REQ-006 SHALL have: cmd_imm_sel in 1 (1 = num2 from immediate); cmd_imm in 8 immediate, zero-extended.
REQ-007 SHALL have: alu_instruction out 5; alu_num1, alu_num2 out 32; alu_result in 32; alu_flags in 4; these connect to the ALU's instruction/num1/num2/result/flags.
REQ-008 SHALL have: wb_valid out 1, wb_rd out 3, wb_data out 32  register-write report.
REQ-009 SHALL have: done out 1, err out 1, flags_q out 4 (architectural flags), dbg_addr in 3, dbg_data out 32.

Function
REQ-010 SHALL contain 8 x 32-bit register file r0..r7; dbg_data = r[dbg_addr] combinationally.
REQ-011 SHALL implement FSM IDLE -> ISSUE -> WB -> IDLE; cmd_ready = 1 only in IDLE.
REQ-012 Accept = cmd_valid && cmd_ready at a rising edge; command fields, r[cmd_rn], r[cmd_rm] latched at that edge; FSM -> ISSUE.
REQ-013 In ISSUE, SHALL drive alu_instruction = cmd_op, alu_num1 = r[rn], alu_num2 = imm_sel ? {24'b0,imm} : r[rm]; held stable through WB.
REQ-014 Unary ops (MVNS 3, UXTB 14, UXTH 15, SXTB 16, SXTH 17) SHALL drive alu_num2 = 0.
REQ-015 ISSUE -> WB unconditionally after one cycle (ALU registers its result on that edge).
REQ-016 At the edge leaving WB, SHALL sample alu_result/alu_flags; write r[rd] = alu_result for ops 1..17; load flags_q = alu_flags for ops 1..18.
REQ-017 CMP (18) SHALL update flags_q only, no register write.
REQ-018 MOVI (19) SHALL write r[rd] = {24'b0,imm}, flags_q unchanged, alu_instruction held 0 throughout.
REQ-019 Illegal op (0, 20..31) SHALL be accepted, traverse ISSUE/WB with alu_instruction 0, write nothing, leave flags_q unchanged.
REQ-020 In the cycle after leaving WB (FSM in IDLE): done = 1 for every command; wb_valid = 1 with wb_rd/wb_data = written index/value iff a register was written; err = 1 iff illegal op; each a single-cycle pulse.
REQ-021 Latency: accept at edge T0 -> register/flag update at T2 -> done/wb_valid high T2..T3; a new command may be accepted at T3; max throughput one per 3 cycles.
REQ-022 When rd equals rn/rm, operands SHALL be the pre-write values (read at accept).
REQ-023 When cmd_valid held during ISSUE/WB, SHALL not accept; command fields may change freely while cmd_ready = 0.
REQ-024 alu_instruction SHALL return to 0 in IDLE; alu_num1/alu_num2 hold last values.

Reset
REQ-025 rst_n low SHALL immediately force: FSM IDLE, r0..r7 = 0, flags_q = 0, alu_instruction = 0, alu_num1 = alu_num2 = 0, wb_valid = done = err = 0, wb_rd = 0, wb_data = 0.
REQ-026 Reset during ISSUE or WB SHALL discard the in-flight command: no write, no flag update, no done pulse after release.
REQ-027 cmd_ready SHALL be 0 while rst_n low and 1 in the first cycle after release.

Verification
REQ-028 MOVI r1=15, MOVI r2=10, ANDS rd=3 rn=1 rm=2 -> wb_valid, wb_rd=3, wb_data=10 at T2 of ANDS; dbg r3 = 10.
REQ-029 MOVI r4=5, MULS rd=5 rn=4 imm_sel=1 imm=4 -> alu_num2=4 during ISSUE, wb_data=20, flags_q = alu_flags sampled.
REQ-030 CMP rn=1 rm=2 (15 vs 10) -> done=1, wb_valid=0, registers unchanged, flags_q updated.
REQ-031 cmd_op=25 -> err=1 and done=1 at T2, wb_valid=0, alu_instruction 0 all cycles, flags_q unchanged.
REQ-032 cmd_valid held high for 4 back-to-back ops -> cmd_ready pattern 1,0,0 repeating; accepts at T0, T3, T6, T9; all four results correct.
REQ-033 Assert rst_n low during WB of ADDS rd=6 -> r6 stays 0, no done pulse, cmd_ready=1 first cycle after release.
